fetch_bp_unit: RTL and testbench

//  Parametrised fetch stage with branch prediction. Holds the PC and predicts the next fetch

---
 rtl/fetch_pkg.sv | 44 ++++
 rtl/bp_sat_counter_table.sv | 36 +++
 rtl/fetch_bp_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_bp_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch / branch-prediction slice.
//  - RV32 control-flow opcodes
//  - 2-bit saturating counter encoding and its update rule
//  - BTB entry layout (tag/target fields sized for the widest supported XLEN)
//  - link-register test used by the optional return-address stack
package fetch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  // Fields are zero-extended into this width; XLEN must not exceed it.
  localparam int unsigned BTB_FIELD_W = 64;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
  } btb_entry_t;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      default: n = taken ? CTR_ST  : CTR_WT;
    endcase
    return n;
  endfunction

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Array of 2-bit saturating counters (branch history table).
//  clk, rst     clock; asynchronous active-low reset, all counters -> CTR_WNT
//  rd_idx       combinational read index
//  rd_ctr       counter at rd_idx (pre-update value in an update cycle)
//  upd_en       train the counter at upd_idx this edge
//  upd_idx      index to train
//  upd_taken    1 = count up, 0 = count down (both saturate)
module bp_sat_counter_table
  import fetch_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned N = 1 << IDX_W;

  ctr_t ctr_mem [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) ctr_mem[i] <= CTR_WNT;
    end else if (upd_en) begin
      ctr_mem[upd_idx] <= ctr_next(ctr_mem[upd_idx], upd_taken);
    end
  end

  assign rd_ctr = ctr_mem[rd_idx];

endmodule

// File: rtl/fetch_bp_unit.sv
// Fetch stage with branch prediction: PC register, 2-bit BHT, tagged
// direct-mapped BTB, optional return-address stack (macro RAS_EN).
//  clk, rst      clock; asynchronous active-low reset
//  pc_write      1 = advance PC, 0 = hold
//  redirect      load redirect_pc (overrides hold)
//  redirect_pc   corrected next PC
//  inst          instruction at pc
//  upd_*         training from the resolve stage
//  pc, pc_plus4  current fetch PC and pc + 4 (wraps)
//  is_branch     inst is B-type, JAL or JALR
//  btb_hit       BTB entry at pc valid with matching tag
//  pred_taken    next fetch steered to pred_target
//  pred_target   BTB target, or RAS top on a predicted return
module fetch_bp_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     BHT_IDX_W = 8,
  parameter int unsigned     BTB_IDX_W = 6,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [31:0]     inst,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            is_branch,
  output logic            btb_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int unsigned BTB_N = 1 << BTB_IDX_W;

  logic [6:0] opcode;
  logic       is_jal;
  logic       is_jalr;
  logic       advance;

  assign opcode    = inst[6:0];
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH) | is_jal | is_jalr;
  assign pc_plus4  = pc + XLEN'(4);
  assign advance   = pc_write & ~redirect;

  // BHT
  ctr_t bht_ctr;

  bp_sat_counter_table #(
    .IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc[BHT_IDX_W+1:2]),
    .rd_ctr   (bht_ctr),
    .upd_en   (upd_valid),
    .upd_idx  (upd_pc[BHT_IDX_W+1:2]),
    .upd_taken(upd_taken)
  );

  // BTB
  btb_entry_t            btb_mem [BTB_N];
  btb_entry_t            btb_rd;
  logic [BTB_IDX_W-1:0]  btb_idx;
  logic [BTB_IDX_W-1:0]  btb_upd_idx;
  logic [XLEN-1:0]       btb_target;
  logic                  bp_pred;

  assign btb_idx     = pc[BTB_IDX_W+1:2];
  assign btb_upd_idx = upd_pc[BTB_IDX_W+1:2];
  assign btb_rd      = btb_mem[btb_idx];
  assign btb_hit     = btb_rd.valid &&
                       (btb_rd.tag == BTB_FIELD_W'(pc[XLEN-1:BTB_IDX_W+2]));
  assign btb_target  = XLEN'(btb_rd.target);
  assign bp_pred     = is_branch & btb_hit & (is_jal | is_jalr | bht_ctr[1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BTB_N; i++) btb_mem[i].valid <= 1'b0;
    end else if (upd_valid && upd_taken) begin
      btb_mem[btb_upd_idx] <= '{valid:  1'b1,
                                tag:    BTB_FIELD_W'(upd_pc[XLEN-1:BTB_IDX_W+2]),
                                target: BTB_FIELD_W'(upd_target)};
    end
  end

`ifdef RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_top_ptr;
  logic [CNT_W-1:0] ras_cnt;
  logic [4:0]       rd_f;
  logic [4:0]       rs1_f;
  logic             is_call;
  logic             ras_pop;

  assign rd_f        = inst[11:7];
  assign rs1_f       = inst[19:15];
  assign is_call     = (is_jal | is_jalr) & is_link(rd_f);
  assign ras_pop     = is_jalr & (rd_f == 5'd0) & is_link(rs1_f) & (ras_cnt != '0);
  assign ras_top_ptr = ras_ptr - PTR_W'(1);

  // ras_ptr is the next free slot; wrapping it overwrites the oldest entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (advance) begin
      case ({ras_pop, is_call})
        2'b10: begin
          ras_ptr <= ras_top_ptr;
          ras_cnt <= ras_cnt - CNT_W'(1);
        end
        2'b01: begin
          ras_mem[ras_ptr] <= pc_plus4;
          ras_ptr          <= ras_ptr + PTR_W'(1);
          if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
        end
        2'b11: begin
          // pop then push collapses to replacing the top in place
          ras_mem[ras_top_ptr] <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

  assign pred_taken  = bp_pred | ras_pop;
  assign pred_target = ras_pop ? ras_mem[ras_top_ptr] : btb_target;
`else
  assign pred_taken  = bp_pred;
  assign pred_target = btb_target;
`endif

  // Next PC
  logic [XLEN-1:0] pc_next;

  always_comb begin
    pc_next = pc;
    if (redirect)        pc_next = redirect_pc;
    else if (pc_write)   pc_next = pred_taken ? pred_target : pc_plus4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= pc_next;
  end

endmodule

// File: tb/tb_fetch_bp_unit.sv
module tb_fetch_bp_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JAL1 = 32'h0000_00EF;  // jal x1, 0
  localparam logic [31:0] RET  = 32'h0000_8067;  // jalr x0, 0(x1)

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_write = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] inst = NOP;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        is_branch;
  logic        btb_hit;
  logic        pred_taken;
  logic [31:0] pred_target;

  fetch_bp_unit #(
    .XLEN     (32),
    .BHT_IDX_W(8),
    .BTB_IDX_W(6),
    .RESET_PC (32'h0),
    .RAS_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_write   (pc_write),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst       (inst),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .is_branch  (is_branch),
    .btb_hit    (btb_hit),
    .pred_taken (pred_taken),
    .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        pw;
    logic        rdr;
    logic [31:0] rpc;
    logic [31:0] ins;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic [31:0] e_pc;
    logic        e_br;
    logic        e_hit;
    logic        e_pt;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic pw, input logic rdr, input logic [31:0] rpc,
                              input logic [31:0] ins, input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [31:0] utgt, input logic [31:0] e_pc,
                              input logic e_br, input logic e_hit, input logic e_pt,
                              input logic [31:0] e_tgt);
    vec_t v;
    v.pw = pw; v.rdr = rdr; v.rpc = rpc; v.ins = ins;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.e_pc = e_pc; v.e_br = e_br; v.e_hit = e_hit; v.e_pt = e_pt; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, let them settle.
  task automatic drv(input logic pw, input logic rdr, input logic [31:0] rpc,
                     input logic [31:0] ins);
    @(negedge clk);
    pc_write = pw; redirect = rdr; redirect_pc = rpc; inst = ins;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //            pw rdr rpc           inst  uv upc       ut utgt      e_pc          br hit pt tgt
    vecs.push_back(mk(1, 0, 32'h0,        NOP, 0, 32'h0,   0, 32'h0,   32'h0,        0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        NOP, 0, 32'h0,   0, 32'h0,   32'h4,        0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        NOP, 0, 32'h0,   0, 32'h0,   32'h8,        0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        NOP, 0, 32'h0,   0, 32'h0,   32'hC,        0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h40,       NOP, 0, 32'h0,   0, 32'h0,   32'h10,       0, 0, 0, 32'h0));
    // train BEQ@0x40 taken twice (lookup sees the pre-update entry)
    vecs.push_back(mk(0, 0, 32'h0,        BEQ, 1, 32'h40,  1, 32'h80,  32'h40,       1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        BEQ, 1, 32'h40,  1, 32'h80,  32'h40,       1, 1, 1, 32'h80));
    vecs.push_back(mk(1, 0, 32'h0,        BEQ, 0, 32'h0,   0, 32'h0,   32'h40,       1, 1, 1, 32'h80));
    // redirect and training in the same cycle; then two more not-taken updates
    vecs.push_back(mk(1, 1, 32'h40,       NOP, 1, 32'h40,  0, 32'h0,   32'h80,       0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        BEQ, 1, 32'h40,  0, 32'h0,   32'h40,       1, 1, 1, 32'h80));
    vecs.push_back(mk(0, 0, 32'h0,        BEQ, 1, 32'h40,  0, 32'h0,   32'h40,       1, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        BEQ, 0, 32'h0,   0, 32'h0,   32'h40,       1, 1, 0, 32'h0));
    // alias 0x140: same BTB index, different tag
    vecs.push_back(mk(1, 1, 32'h140,      NOP, 0, 32'h0,   0, 32'h0,   32'h44,       0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        BEQ, 0, 32'h0,   0, 32'h0,   32'h140,      1, 0, 0, 32'h0));
    // redirect beats hold, then hold for three cycles
    vecs.push_back(mk(0, 1, 32'h200,      NOP, 0, 32'h0,   0, 32'h0,   32'h144,      0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        NOP, 0, 32'h0,   0, 32'h0,   32'h200,      0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        NOP, 0, 32'h0,   0, 32'h0,   32'h200,      0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        NOP, 0, 32'h0,   0, 32'h0,   32'h200,      0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        NOP, 0, 32'h0,   0, 32'h0,   32'h200,      0, 0, 0, 32'h0));
    // saturation at 0x208: five taken, one not-taken -> 2'b10
    vecs.push_back(mk(0, 0, 32'h0,        NOP, 1, 32'h208, 1, 32'h300, 32'h204,      0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        NOP, 1, 32'h208, 1, 32'h300, 32'h204,      0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        NOP, 1, 32'h208, 1, 32'h300, 32'h204,      0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        NOP, 1, 32'h208, 1, 32'h300, 32'h204,      0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        NOP, 1, 32'h208, 1, 32'h300, 32'h204,      0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,        NOP, 1, 32'h208, 0, 32'h0,   32'h204,      0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        NOP, 0, 32'h0,   0, 32'h0,   32'h204,      0, 0, 0, 32'h0));
    // lookup + not-taken update on same index: old counter (10) predicts taken
    vecs.push_back(mk(1, 0, 32'h0,        BEQ, 1, 32'h208, 0, 32'h0,   32'h208,      1, 1, 1, 32'h300));
    vecs.push_back(mk(1, 1, 32'h208,      NOP, 0, 32'h0,   0, 32'h0,   32'h300,      0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        BEQ, 0, 32'h0,   0, 32'h0,   32'h208,      1, 1, 0, 32'h0));
    // pc_plus4 wrap
    vecs.push_back(mk(1, 1, 32'hFFFF_FFFC, NOP, 0, 32'h0,  0, 32'h0,   32'h20C,      0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        NOP, 0, 32'h0,   0, 32'h0,   32'hFFFF_FFFC, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,        NOP, 0, 32'h0,   0, 32'h0,   32'h0,        0, 0, 0, 32'h0));

    // reset state
    @(negedge clk);
    #1;
    check("reset_pc", pc, 32'h0);
    check("reset_hit", {31'b0, btb_hit}, 32'h0);
    check("reset_pt", {31'b0, pred_taken}, 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      pc_write = vecs[i].pw; redirect = vecs[i].rdr; redirect_pc = vecs[i].rpc;
      inst = vecs[i].ins; upd_valid = vecs[i].uv; upd_pc = vecs[i].upc;
      upd_taken = vecs[i].ut; upd_target = vecs[i].utgt;
      #1;
      check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].e_pc + 32'd4);
      check($sformatf("v%0d_is_branch", i), {31'b0, is_branch}, {31'b0, vecs[i].e_br});
      check($sformatf("v%0d_btb_hit", i), {31'b0, btb_hit}, {31'b0, vecs[i].e_hit});
      check($sformatf("v%0d_pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].e_pt});
      if (vecs[i].e_pt) check($sformatf("v%0d_pred_target", i), pred_target, vecs[i].e_tgt);
    end

    // reset asserted mid-redirect, mid-stall; BTB must come back invalid
    drv(0, 1, 32'h40, NOP);
    drv(0, 1, 32'h500, BEQ);
    check("pre_rst_pc", pc, 32'h40);
    check("pre_rst_hit", {31'b0, btb_hit}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_pt", {31'b0, pred_taken}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h40; pc_write = 1'b0; inst = NOP;
    #1;
    check("rst_held_pc", pc, 32'h0);
    drv(0, 0, 32'h0, BEQ);
    check("post_rst_pc", pc, 32'h40);
    check("post_rst_hit", {31'b0, btb_hit}, 32'h0);
    check("post_rst_pt", {31'b0, pred_taken}, 32'h0);

`ifdef RAS_EN
    drv(0, 1, 32'h100, NOP);
    drv(1, 0, 32'h0, JAL1);
    check("ras_call_pc", pc, 32'h100);
    drv(1, 1, 32'h300, NOP);
    check("ras_fall_pc", pc, 32'h104);
    drv(1, 0, 32'h0, RET);
    check("ras_ret_pc", pc, 32'h300);
    check("ras_ret_pt", {31'b0, pred_taken}, 32'h1);
    check("ras_ret_tgt", pred_target, 32'h104);
    drv(1, 0, 32'h0, NOP);
    check("ras_ret_next", pc, 32'h104);
    for (int k = 0; k < 5; k++) begin
      drv(1, 1, 32'h1000 + 32'(k) * 32'h10, NOP);
      drv(1, 0, 32'h0, JAL1);
      check($sformatf("ras_call%0d_pc", k), pc, 32'h1000 + 32'(k) * 32'h10);
    end
    for (int k = 0; k < 4; k++) begin
      drv(1, 0, 32'h0, RET);
      check($sformatf("ras_pop%0d_pt", k), {31'b0, pred_taken}, 32'h1);
      check($sformatf("ras_pop%0d_tgt", k), pred_target, 32'h1044 - 32'(k) * 32'h10);
    end
    drv(1, 0, 32'h0, RET);
    check("ras_empty_pc", pc, 32'h1014);
    check("ras_empty_pt", {31'b0, pred_taken}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
